// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional macro BIN2BCD_SIGNED_EN is consumed by the interface and top, not here.
package bin2bcd_pkg;

    typedef enum logic {IDLE, SHIFT} bcd_state_t;

    localparam int BCD_DIGIT_W          = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake plus data bus of the converter; master = requester, slave = converter.
// Latency: n/a (wiring only). Backpressure: start is ignored while busy is high.
// With BIN2BCD_SIGNED_EN defined the bus carries an extra sign flag (neg).
interface bin2bcd_seq_if
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                          start;
    logic [WIDTH-1:0]              bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
`ifdef BIN2BCD_SIGNED_EN
    logic                          neg;

    modport master (output start, bin, input busy, done, bcd, neg);
    modport slave  (input start, bin, output busy, done, bcd, neg);
`else
    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/bin2bcd_seq_dabble_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the shift.
// Latency: combinational. Backpressure: none.
module dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] dig_i,
    output logic [BCD_DIGIT_W-1:0] dig_o
);
    always_comb begin
        dig_o = (dig_i >= BCD_ADJ_THRESH) ? dig_i + BCD_ADJ : dig_i;
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock (macro BIN2BCD_SIGNED_EN: two's complement input + neg flag).
// Latency: WIDTH edges from the accepting edge to done; next acceptance one edge after done.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)(
    input  logic          clk,
    input  logic          n_reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "bin2bcd_seq: WIDTH must be within 4..16");
    end
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
        $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
    end

    bcd_state_t       state_q;
    logic [WIDTH-1:0] sh_q, sh_d, load_val;
    logic [BCD_W-1:0] scr_q, scr_d, adj;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic [BCD_W-1:0] bcd_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        dabble_digit u_dig (
            .dig_i (scr_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dig_o (adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        scr_d = {adj[BCD_W-2:0], sh_q[WIDTH-1]};
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
    end

`ifdef BIN2BCD_SIGNED_EN
    // One extra bit so that the most negative input yields its true magnitude.
    logic [WIDTH:0] mag;
    logic           sign_q, neg_q;
    always_comb begin
        mag      = bus.bin[WIDTH-1] ? ({1'b0, ~bus.bin} + 1'b1) : {1'b0, bus.bin};
        load_val = mag[WIDTH-1:0];
    end
    assign bus.neg = neg_q;
`else
    always_comb begin
        load_val = bus.bin;
    end
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sh_q    <= load_val;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
                        sign_q  <= bus.bin[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    scr_q <= scr_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The final shift lands the result straight into bcd.
                    if (cnt_q == LAST_CNT) begin
                        bcd_q   <= scr_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef BIN2BCD_SIGNED_EN
                        neg_q   <= sign_q;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq; stimulus driven and sampled on the falling edge.
module tb_bin2bcd_seq;
    localparam int W = 8;
    localparam int D = 3;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int n;
    int ndone;
    logic busy_ok;
    logic hold_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        while (!bus.done && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_conv(input string tag, input logic [7:0] v, input logic [11:0] exp_bcd,
                            input logic exp_neg);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 8'hA5;
        chk({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        n = 0;
        busy_ok = 1'b1;
        wait_done();
        chk({tag, "_latency"}, n, W);
        chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
`ifdef BIN2BCD_SIGNED_EN
        chk({tag, "_neg"}, 32'(bus.neg), 32'(exp_neg));
`else
        if (exp_neg) $display("note: sign expectation ignored in unsigned build (%s)", tag);
`endif
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, "_bcd_hold"}, 32'(bus.bcd), 32'(exp_bcd));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bin   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bcd", 32'(bus.bcd), 32'h000);
        n_reset = 1'b1;

        // Basic conversions
        run_conv("zero", 8'd0,   12'h000, 1'b0);
        run_conv("v255", 8'd255, 12'h255, 1'b0);
        run_conv("v128", 8'd128, 12'h128, 1'b0);
        run_conv("v9",   8'd9,   12'h009, 1'b0);
        run_conv("v10",  8'd10,  12'h010, 1'b0);

        // Start while busy is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd37;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        repeat (2) begin @(negedge clk); n++; end
        bus.start = 1'b1;
        bus.bin   = 8'd99;
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        busy_ok = 1'b1;
        wait_done();
        chk("ign_latency", n, W);
        chk("ign_bcd", 32'(bus.bcd), 32'h037);
        ndone = 0;
        repeat (20) begin @(negedge clk); if (bus.done) ndone++; end
        chk("ign_no_second_done", ndone, 0);
        chk("ign_bcd_hold", 32'(bus.bcd), 32'h037);

        // Start held high: back-to-back conversions
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd200;
        @(negedge clk);
        n = 0;
        bus.bin = 8'd45;
        busy_ok = 1'b1;
        wait_done();
        chk("b2b_first_latency", n, W);
        chk("b2b_first_bcd", 32'(bus.bcd), 32'h200);
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        hold_ok = 1'b1;
        while (!bus.done && n < 60) begin
            if (bus.bcd !== 12'h200) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("b2b_hold_between", 32'(hold_ok), 32'd1);
        chk("b2b_second_edge", n, 2 * W + 1);
        chk("b2b_second_bcd", 32'(bus.bcd), 32'h045);

        // Asynchronous reset mid-conversion
        run_conv("v123", 8'd123, 12'h123, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd50;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_bcd", 32'(bus.bcd), 32'h000);
        @(negedge clk);
        n_reset = 1'b1;
        ndone = 0;
        repeat (20) begin @(negedge clk); if (bus.done) ndone++; end
        chk("arst_no_done", ndone, 0);
        chk("arst_idle_busy", 32'(bus.busy), 32'd0);

`ifdef BIN2BCD_SIGNED_EN
        run_conv("s80", 8'h80, 12'h128, 1'b1);
        run_conv("sFF", 8'hFF, 12'h001, 1'b1);
        run_conv("s7F", 8'h7F, 12'h127, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
